// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack control sequencer: fetch, decode, optional M read, execute, optional M write.
// Holds A/D/PC and drives an external ALU plus handshaked ROM and data-memory ports.
module hack_cpu_ctrl (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req,
  output logic [14:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_s,
  input  logic [15:0] alu_c,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] pc_out,
  output logic [15:0] a_out,
  output logic [15:0] d_out,
  output logic        retire
);

  typedef enum logic [2:0] {FETCH, DECODE, LOAD_M, EXEC, STORE} state_t;

  state_t      state, state_nx;
  logic [15:0] ir, a, d, m, wdata;
  logic [14:0] pc, waddr;
  logic        jump;

  assign jump   = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr);
  assign pc_out = pc;
  assign a_out  = a;
  assign d_out  = d;

  // Outputs are masked while rst is high so an in-flight request drops at once.
  always_comb begin
    state_nx  = state;
    rom_req   = 1'b0;
    rom_addr  = 15'h0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 15'h0;
    mem_wdata = 16'h0;
    alu_x     = 16'h0;
    alu_y     = 16'h0;
    alu_s     = 6'h0;
    retire    = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          rom_req  = 1'b1;
          rom_addr = pc;
          if (rom_ack) state_nx = DECODE;
        end
        DECODE: begin
          if (!ir[15]) begin
            retire   = 1'b1;
            state_nx = FETCH;
          end else begin
            state_nx = ir[12] ? LOAD_M : EXEC;
          end
        end
        LOAD_M: begin
          mem_req  = 1'b1;
          mem_addr = a[14:0];
          if (mem_ack) state_nx = EXEC;
        end
        EXEC: begin
          alu_x = d;
          alu_y = ir[12] ? m : a;
          alu_s = ir[11:6];
          if (ir[3]) begin
            state_nx = STORE;
          end else begin
            retire   = 1'b1;
            state_nx = FETCH;
          end
        end
        STORE: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = waddr;
          mem_wdata = wdata;
          if (mem_ack) begin
            retire   = 1'b1;
            state_nx = FETCH;
          end
        end
        default: state_nx = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= 15'h0;
      a     <= 16'h0;
      d     <= 16'h0;
      ir    <= 16'h0;
      m     <= 16'h0;
      waddr <= 15'h0;
      wdata <= 16'h0;
    end else begin
      state <= state_nx;
      case (state)
        FETCH:  if (rom_ack) ir <= rom_data;
        DECODE: if (!ir[15]) begin
          a  <= ir;
          pc <= pc + 15'd1;
        end
        LOAD_M: if (mem_ack) m <= mem_rdata;
        EXEC: begin
          // Jump target and store address both use A from before this write-back.
          if (ir[5]) a <= alu_c;
          if (ir[4]) d <= alu_c;
          pc <= jump ? a[14:0] : pc + 15'd1;
          if (ir[3]) begin
            waddr <= a[14:0];
            wdata <= alu_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
